// File: rtl/spi_slave_if.sv
// SPI slave bus bundle: the four SPI wires plus the receive and transmit
// handshakes seen by the local consumer/producer.
interface spi_slave_if #(
  parameter int WIDTH = 8
);
  logic             sclk;
  logic             ss;
  logic             mosi;
  logic             miso;

  // rx_valid holds until the cycle after rx_ack is seen with rx_valid=1;
  // tx_load is accepted only on a cycle where tx_ready=1.
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             rx_ack;
  logic             rx_overrun;
  logic [WIDTH-1:0] tx_data;
  logic             tx_load;
  logic             tx_ready;

  modport slave (
    input  sclk, ss, mosi, rx_ack, tx_data, tx_load,
    output miso, rx_data, rx_valid, rx_overrun, tx_ready
  );

  modport master (
    output sclk, ss, mosi, rx_ack, tx_data, tx_load,
    input  miso, rx_data, rx_valid, rx_overrun, tx_ready
  );
endinterface

// File: rtl/spi_slave.sv
// Oversampled mode-0 SPI slave: synchronized SPI pins, MSB-first shift
// registers, one-deep transmit buffer and a valid/ack receive register.
module spi_slave #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  spi_slave_if.slave bus,
  output logic [1:0] fsm_state
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  // Input conditioning: SYNC_STAGES flops per pin, plus one delayed copy
  // of the last stage for edge detection. SYNC_STAGES must be at least 2.
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_d;
  logic                   ss_d;
  logic                   sclk_s;
  logic                   ss_s;
  logic                   mosi_s;
  logic                   sclk_rise;
  logic                   sclk_fall;
  logic                   ss_fall;
  logic                   ss_rise;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], bus.ss};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      ss_d      <= ss_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise =  sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s &  sclk_d;
  assign ss_fall   = ~ss_s   &  ss_d;
  assign ss_rise   =  ss_s   & ~ss_d;

  // Control state
  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    bit_cnt;
  logic             reload;
  logic             tx_fill;
  logic             tx_shift_en;
  logic             rx_shift_en;
  logic             word_done;

  // Datapath state
  logic [WIDTH-1:0] rx_shift;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             rx_overrun;
  logic [WIDTH-1:0] tx_shift;
  logic [WIDTH-1:0] tx_buf;
  logic             tx_full;
  logic             miso;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    tx_fill     = 1'b0;
    tx_shift_en = 1'b0;
    rx_shift_en = 1'b0;
    word_done   = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        tx_fill    = 1'b1;
        state_next = SHIFT;
      end
      SHIFT: begin
        // A full count is retired the cycle after the last rising edge.
        if (bit_cnt == CW'(WIDTH)) begin
          word_done = 1'b1;
        end else if (sclk_rise) begin
          rx_shift_en = 1'b1;
        end
        if (sclk_fall) begin
          if (reload) begin
            tx_fill = 1'b1;
          end else begin
            tx_shift_en = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // Deselect aborts whatever is in flight, from any state.
    if (ss_rise) begin
      state_next  = IDLE;
      tx_fill     = 1'b0;
      tx_shift_en = 1'b0;
      rx_shift_en = 1'b0;
      word_done   = 1'b0;
    end
  end

  assign fsm_state = state;

  // Receive path and consumer handshake
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_shift   <= '0;
      bit_cnt    <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= word_done & rx_valid & ~bus.rx_ack;
      if (ss_rise) begin
        bit_cnt <= '0;
      end else if (rx_shift_en) begin
        rx_shift <= {rx_shift[WIDTH-2:0], mosi_s};
        bit_cnt  <= bit_cnt + CW'(1);
      end else if (word_done) begin
        bit_cnt <= '0;
      end
      if (word_done) begin
        rx_data  <= rx_shift;
        rx_valid <= 1'b1;
      end else if (rx_valid && bus.rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end

  // Transmit path: reload flag, shift register, buffer and miso register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reload   <= 1'b0;
      tx_shift <= '0;
      tx_buf   <= '0;
      tx_full  <= 1'b0;
      miso     <= 1'b0;
    end else begin
      if (ss_rise) begin
        reload <= 1'b0;
      end else if (word_done) begin
        reload <= 1'b1;
      end else if (tx_fill) begin
        reload <= 1'b0;
      end

      if (tx_fill) begin
        tx_shift <= tx_full ? tx_buf : '0;
      end else if (tx_shift_en) begin
        tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
      end else if (ss_rise) begin
        tx_shift <= '0;
      end

      // Consume and accept can never coincide: one needs full, one empty.
      if (tx_fill && tx_full) begin
        tx_full <= 1'b0;
      end else if (bus.tx_load && !tx_full) begin
        tx_full <= 1'b1;
        tx_buf  <= bus.tx_data;
      end

      miso <= (state == SHIFT) ? tx_shift[WIDTH-1] : 1'b0;
    end
  end

  assign bus.miso       = miso;
  assign bus.rx_data    = rx_data;
  assign bus.rx_valid   = rx_valid;
  assign bus.rx_overrun = rx_overrun;
  assign bus.tx_ready   = ~tx_full;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a pin-level SPI master, a transaction-level model of
// the receive/transmit handshakes, and a per-cycle compare process.
module tb_spi_slave;

  localparam int W    = 8;
  localparam int S    = 2;
  localparam int HALF = 10;

  // Clock / reset
  logic       clk;
  logic       reset;
  logic [1:0] fsm_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  spi_slave_if #(.WIDTH(W)) bus ();

  spi_slave #(
    .WIDTH       (W),
    .SYNC_STAGES (S)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // Scoreboard state
  int               n_cmp = 0;
  int               n_bad = 0;
  int               n_over = 0;
  int               cyc = 0;
  bit               rand_mode = 1'b0;
  logic [W-1:0]     exp_q[$];
  int               ev_due[$];
  int               ev_kind[$];
  logic [W-1:0]     ev_word[$];
  logic             exp_valid = 1'b0;
  logic             exp_over = 1'b0;
  logic             exp_full = 1'b0;
  logic [W-1:0]     exp_data = '0;
  logic [W-1:0]     exp_buf = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push_event(input int due, input int kind, input logic [W-1:0] d);
    ev_due.push_back(due);
    ev_kind.push_back(kind);
    ev_word.push_back(d);
  endtask

  // Model: kind 0 = a received word becomes visible, kind 1 = the transmit
  // buffer is drained into the shifter (empty buffer -> zeros go out).
  initial begin : model
    logic         ack_s, load_s, rst_s, word_due, cons_due, nfull;
    logic [W-1:0] data_s, w;
    forever begin
      @(posedge clk);
      ack_s  = bus.rx_ack;
      load_s = bus.tx_load;
      data_s = bus.tx_data;
      rst_s  = reset;
      cyc++;
      if (!rst_s) begin
        exp_valid = 1'b0;
        exp_over  = 1'b0;
        exp_full  = 1'b0;
        exp_data  = '0;
        exp_buf   = '0;
        ev_due.delete();
        ev_kind.delete();
        ev_word.delete();
        exp_q.delete();
      end else begin
        word_due = 1'b0;
        cons_due = 1'b0;
        w        = '0;
        for (int i = ev_due.size() - 1; i >= 0; i--) begin
          if (ev_due[i] == cyc) begin
            if (ev_kind[i] == 0) begin
              word_due = 1'b1;
              w        = ev_word[i];
            end else begin
              cons_due = 1'b1;
            end
            ev_due.delete(i);
            ev_kind.delete(i);
            ev_word.delete(i);
          end
        end
        if (word_due) begin
          exp_over  = exp_valid && !ack_s;
          exp_valid = 1'b1;
          exp_data  = w;
        end else begin
          exp_over = 1'b0;
          if (exp_valid && ack_s) exp_valid = 1'b0;
        end
        nfull = exp_full;
        if (cons_due) begin
          exp_q.push_back(exp_full ? exp_buf : '0);
          nfull = 1'b0;
        end
        if (load_s && !exp_full) begin
          nfull   = 1'b1;
          exp_buf = data_s;
        end
        exp_full = nfull;
      end
      #1;
      check("rx_valid", {31'd0, bus.rx_valid}, {31'd0, exp_valid});
      check("rx_data", {24'd0, bus.rx_data}, {24'd0, exp_data});
      check("rx_overrun", {31'd0, bus.rx_overrun}, {31'd0, exp_over});
      check("tx_ready", {31'd0, bus.tx_ready}, {31'd0, !exp_full});
      if (bus.rx_overrun) n_over++;
    end
  end

  // Driver tasks
  task automatic wait_half(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rand_mode) begin
        bus.rx_ack  = ($urandom_range(0, 3) == 0);
        bus.tx_load = ($urandom_range(0, 5) == 0);
        bus.tx_data = W'($urandom);
      end else begin
        bus.rx_ack  = 1'b0;
        bus.tx_load = 1'b0;
      end
    end
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    bus.rx_ack = 1'b1;
    @(negedge clk);
    bus.rx_ack = 1'b0;
  endtask

  task automatic tx_put(input logic [W-1:0] v);
    @(negedge clk);
    bus.tx_data = v;
    bus.tx_load = 1'b1;
    @(negedge clk);
    bus.tx_load = 1'b0;
  endtask

  // ld=1 presents tx_load exactly on the edge where the slave loads its shifter.
  task automatic spi_begin(input bit ld, input logic [W-1:0] v);
    bus.ss = 1'b0;
    push_event(cyc + S + 2, 1, '0);
    if (ld) begin
      repeat (S + 1) @(negedge clk);
      bus.tx_data = v;
      bus.tx_load = 1'b1;
      @(negedge clk);
      bus.tx_load = 1'b0;
    end
    wait_half(HALF);
  endtask

  task automatic spi_word(input logic [W-1:0] data, input int nbits, output logic [W-1:0] got);
    logic [W-1:0] exp_tx;
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = data[W-1-i];
      wait_half(HALF);
      got = {got[W-2:0], bus.miso};
      bus.sclk = 1'b1;
      if (i == W - 1) push_event(cyc + S + 2, 0, data);
      wait_half(HALF);
      bus.sclk = 1'b0;
      if (i == W - 1) push_event(cyc + S + 1, 1, '0);
    end
    if (exp_q.size() == 0) begin
      check("miso_queue", 32'd0, 32'd1);
    end else begin
      exp_tx = exp_q.pop_front();
      if (nbits == W) check("miso_word", {24'd0, got}, {24'd0, exp_tx});
    end
  endtask

  task automatic spi_end();
    wait_half(HALF);
    bus.ss = 1'b1;
    wait_half(HALF);
    exp_q.delete();
  endtask

  task automatic check_reset_values();
    check("rst_miso", {31'd0, bus.miso}, 32'd0);
    check("rst_rx_data", {24'd0, bus.rx_data}, 32'd0);
    check("rst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
    check("rst_rx_overrun", {31'd0, bus.rx_overrun}, 32'd0);
    check("rst_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
    check("rst_state", {30'd0, fsm_state}, 32'd0);
  endtask

  // Watchdog
  initial begin
    #5_000_000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: run did not complete, got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Main sequence
  initial begin
    logic [W-1:0] got;
    logic [W-1:0] got2;
    int           ov0;
    int           nw;
    reset       = 1'b0;
    bus.sclk    = 1'b0;
    bus.ss      = 1'b1;
    bus.mosi    = 1'b0;
    bus.rx_ack  = 1'b0;
    bus.tx_load = 1'b0;
    bus.tx_data = '0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_values();
    @(negedge clk);
    reset = 1'b1;
    wait_half(4);

    // Single word with a preloaded reply
    tx_put(8'h3C);
    check("tx_ready_full", {31'd0, bus.tx_ready}, 32'd0);
    spi_begin(1'b0, '0);
    check("tx_ready_after_load", {31'd0, bus.tx_ready}, 32'd1);
    spi_word(8'hA5, W, got);
    check("lit_miso_3c", {24'd0, got}, 32'h3C);
    check("lit_rx_a5", {24'd0, bus.rx_data}, 32'hA5);
    check("lit_valid_a5", {31'd0, bus.rx_valid}, 32'd1);
    pulse_ack();
    spi_end();

    // Back-to-back words, buffer refilled between them
    tx_put(8'h3C);
    spi_begin(1'b0, '0);
    spi_word(8'h12, W, got);
    tx_put(8'hC3);
    pulse_ack();
    spi_word(8'h34, W, got2);
    check("lit_b2b_first", {24'd0, got}, 32'h3C);
    check("lit_b2b_second", {24'd0, got2}, 32'hC3);
    pulse_ack();
    spi_end();

    // Overrun: two words, no acknowledge
    ov0 = n_over;
    spi_begin(1'b0, '0);
    spi_word(8'h12, W, got);
    spi_word(8'h34, W, got);
    spi_end();
    check("lit_overrun_data", {24'd0, bus.rx_data}, 32'h34);
    check("lit_overrun_valid", {31'd0, bus.rx_valid}, 32'd1);
    check("lit_overrun_pulses", n_over - ov0, 32'd1);
    pulse_ack();

    // Empty buffer with tx_load landing on the load cycle
    spi_begin(1'b1, 8'h66);
    spi_word(8'h0F, W, got);
    pulse_ack();
    spi_word(8'hF0, W, got2);
    check("lit_empty_zeros", {24'd0, got}, 32'h00);
    check("lit_next_word", {24'd0, got2}, 32'h66);
    pulse_ack();
    spi_end();

    // Deselect after 5 bits, then a full word
    spi_begin(1'b0, '0);
    spi_word(8'hFF, 5, got);
    spi_end();
    check("lit_partial_novalid", {31'd0, bus.rx_valid}, 32'd0);
    spi_begin(1'b0, '0);
    spi_word(8'h81, W, got);
    check("lit_rx_81", {24'd0, bus.rx_data}, 32'h81);
    pulse_ack();
    spi_end();

    // Reset mid-word
    tx_put(W'($urandom));
    spi_begin(1'b0, '0);
    spi_word(W'($urandom), 4, got);
    reset = 1'b0;
    #1;
    check_reset_values();
    bus.ss   = 1'b1;
    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    wait_half(HALF);
    spi_begin(1'b0, '0);
    spi_word(8'h5A, W, got);
    check("lit_rx_5a", {24'd0, bus.rx_data}, 32'h5A);
    check("lit_miso_after_reset", {24'd0, got}, 32'h00);
    pulse_ack();
    spi_end();

    // Randomized transfers with random ack and buffer traffic
    rand_mode = 1'b1;
    for (int t = 0; t < 15; t++) begin
      spi_begin(1'b0, '0);
      nw = $urandom_range(1, 3);
      for (int k = 0; k < nw; k++) spi_word(W'($urandom), W, got);
      if ($urandom_range(0, 4) == 0) spi_word(W'($urandom), $urandom_range(1, W - 1), got);
      spi_end();
    end
    rand_mode = 1'b0;
    wait_half(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
# spi_slave

Oversampled SPI slave that sits directly downstream of the `master` SPI block, on the far end of its `sclk`/`ss`/`mosi`/`miso` wires. It runs entirely on its own system clock and treats the SPI lines as asynchronous inputs, sampling them through synchronizers. Each received MOSI byte is delivered on a valid/ack handshake, and the byte to return on MISO is taken from a one-deep transmit buffer. Bus format is mode 0, MSB first.

## Interface
- `WIDTH`, default 8: bits per SPI word.
- `SYNC_STAGES`, default 2: flip-flop stages on each SPI input (minimum 2).
- `clk` input 1: system clock. One clock, all logic on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `sclk` input 1: SPI clock from the master, asynchronous to `clk`.
- `ss` input 1: active-low slave select, asynchronous.
- `mosi` input 1: master-out data, asynchronous.
- `miso` output 1: slave-out data.
- `rx_data` output WIDTH: last complete received word.
- `rx_valid` output 1: `rx_data` holds an unacknowledged word.
- `rx_ack` input 1: consumer accepts `rx_data`.
- `rx_overrun` output 1: one-cycle pulse; a word was overwritten before it was acknowledged.
- `tx_data` input WIDTH: next word to send.
- `tx_load` input 1: write `tx_data` into the transmit buffer.
- `tx_ready` output 1: transmit buffer is empty.

## Operation
- Input conditioning:
  - `sclk`, `ss` and `mosi` each pass through SYNC_STAGES flops.
  - Synchronizer reset values: `sclk` 0, `ss` 1, `mosi` 0.
  - Edge detects use the last synchronized stage against a one-cycle-delayed copy: `sclk` rise, `sclk` fall, `ss` fall, `ss` rise.
- State machine: IDLE, LOAD, SHIFT.
  - IDLE: `miso`=0, bit count=0. On `ss` fall, go to LOAD.
  - LOAD (1 cycle):
    - If the buffer is full, the TX shift register gets the buffer contents, the buffer is emptied and the machine goes to SHIFT.
    - Otherwise the shift register gets all zeros.
    - `miso` = shift MSB from the next cycle.
  - SHIFT, on `sclk` rise:
    - Shift synchronized `mosi` into the RX shift register LSB and increment the bit count.
    - When the count reaches WIDTH: copy the RX shift register to `rx_data`, set `rx_valid`, clear the count, and flag a reload.
  - SHIFT, on `sclk` fall:
    - If the reload flag is set, load the TX shift register as in LOAD and clear the flag.
    - Otherwise shift the TX register left and drive `miso` with the new MSB.
  - SHIFT, on `ss` rise (any state): go to IDLE.
    - The partial RX word is discarded: no `rx_valid`, count cleared.
    - TX shift contents are discarded; an unconsumed buffer word is kept.
- RX handshake:
  - `rx_valid` clears on the cycle after `rx_ack` while `rx_valid`=1.
  - A word completing while `rx_valid`=1 and `rx_ack`=0: `rx_data` is overwritten, `rx_valid` stays 1, and `rx_overrun` pulses for 1 cycle.
  - A word completing in the same cycle as `rx_ack`: the new word wins, `rx_valid` stays 1, no overrun.
- TX handshake:
  - `tx_load` with `tx_ready`=1 writes the buffer; `tx_ready`=0 next cycle.
  - `tx_load` with `tx_ready`=0 is ignored.
  - When the buffer is consumed, `tx_ready`=1 the next cycle.
  - `tx_load` in the same cycle as a load from an empty buffer: zeros are shifted out, and `tx_data` lands in the buffer for the following word.

## Timing
- Reset values: `miso` 0, `rx_data` 0, `rx_valid` 0, `rx_overrun` 0, `tx_ready` 1, state IDLE, count 0, reload flag 0.
- Input latency: a pin edge is detected SYNC_STAGES+1 `clk` edges after it occurs.
- `rx_valid` rises SYNC_STAGES+2 `clk` edges after the WIDTH-th `sclk` rise at the pin.
- First `miso` bit is valid SYNC_STAGES+3 `clk` edges after `ss` falls at the pin.
- Later `miso` bits update SYNC_STAGES+2 edges after each `sclk` fall at the pin.
- Master constraints:
  - `sclk` high and low phases each ≥ 2·(SYNC_STAGES+2) `clk` periods.
  - `ss` fall to first `sclk` rise ≥ the same bound.
  - `mosi` stable across each `sclk` rise for ≥ SYNC_STAGES `clk` periods.
- Back-to-back words with `ss` held low are supported with no gap cycles.
- Reset mid-transfer: all state is cleared immediately; the slave waits for a new `ss` fall.

## Test plan
- Reset, then master sends 0xA5 with `tx_data`=0x3C preloaded -> `rx_data`=0xA5, `rx_valid`=1 at the specified latency; master receives 0x3C; `tx_ready` returns to 1 after LOAD.
- Two words 0x12, 0x34 with `ss` held low, `rx_ack` pulsed after each, buffer refilled with 0xC3 between words -> two `rx_valid` events; master receives 0x3C then 0xC3.
- Two words with no `rx_ack` -> `rx_data`=0x34, one `rx_overrun` pulse, `rx_valid` stays 1.
- Word sent with the buffer empty -> `miso` all zeros; `tx_load` during the transfer is used for the next word.
- `ss` raised after 5 bits, then a full 0x81 word -> no `rx_valid` for the partial word; next `rx_data`=0x81.
- `reset` asserted mid-word -> all outputs at reset values within 0 `clk` edges; a subsequent 0x5A transfer is received correctly.
